rr_mux4_arbiter: RTL and testbench
==================================

# rr_mux4_arbiter

Round-robin packet arbiter that shares one N-bit output channel between four requesters. The data path is steered through a 4:1 N-bit mux. The block picks a requester and locks the channel to it until its packet ends with a `last` beat or hits a beat limit. It then rotates priority to the next requester. It sits between four producer blocks and a single downstream consumer that uses a valid/ready handshake.

## Interface
Parameters:
- `N`, default 4: data width per requester.
- `MAX_BEATS`, default 8: maximum beats per grant before forced release; legal range ≥1.

Ports:
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: asynchronous, active-high; clears all state immediately.
- `req` input, 4: per-requester valid; bit i means `xi` holds a beat.
- `last` input, 4: per-requester end-of-packet flag, qualified by `req[i]`.
- `x0`, `x1`, `x2`, `x3` input, N each: requester data.
- `ready_o` output, 4: per-requester ready; one-hot or zero.
- `out_valid` output, 1: downstream valid.
- `out_ready` input, 1: downstream ready.
- `out_data` output, N: muxed data.
- `out_last` output, 1: end of packet; also asserted on a forced release.
- `out_sel` output, 2: index of the granted requester.
- `busy` output, 1: high while in LOCKED.
- `trunc` output, 1: one-cycle pulse on a forced release.

## Operation
State machine states: IDLE, LOCKED. The registers are:
- `ptr` (2b): priority pointer.
- `sel` (2b): granted index.
- `beat_cnt` (width clog2(MAX_BEATS+1)): beats transferred in the current grant.

IDLE:
- `out_valid`=0, `ready_o`=0, `busy`=0.
- If `req`≠0, scan the indices `ptr`, `ptr`+1, … mod 4.
- Load `sel` with the first index whose `req` is set, clear `beat_cnt`, and go to LOCKED.

LOCKED:
- `out_sel`=`sel` and `out_data`=x[`sel`].
- `out_valid`=`req[sel]`.
- `ready_o[sel]`=`out_ready`; all other `ready_o` bits are 0.
- A transfer occurs when `out_valid` && `out_ready`. On each transfer, `beat_cnt` increments.

`out_last` in LOCKED:
- `out_last`=`req[sel]` && (`last[sel]` || `beat_cnt`==MAX_BEATS−1).

Release happens on a transfer with `out_last`=1:
- `ptr` <= `sel`+1 (wraps 3→0).
- Return to IDLE.
- If the release was caused by the beat limit and `last[sel]`=0, pulse `trunc` for one cycle. That requester may be regranted later and continues its packet.

Rules:
- The grant does not change mid-packet. If `req[sel]` drops while LOCKED, the block stays LOCKED with `out_valid`=0 until `req[sel]` returns. Other requesters are ignored meanwhile.
- `req` changes from non-granted requesters while LOCKED have no effect.
- `out_data` is don't-care when `out_valid`=0. It still follows x[`sel`].

## Timing
- Reset values: state IDLE, `ptr`=0, `sel`=0, `beat_cnt`=0. All outputs are 0, and `out_data` = `x0`.
- Asserting `reset` mid-packet drops `out_valid` and `ready_o` combinationally-from-reset. No beat is transferred in that cycle.
- Arbitration latency:
  - `req` is seen in IDLE at edge t.
  - LOCKED begins after edge t.
  - `out_valid` is high in cycle t+1 if `req[sel]` is still held.
- Data path is combinational from `x[sel]` to `out_data`. There is no data register.
- There is one IDLE bubble cycle between consecutive grants, so peak throughput is MAX_BEATS/(MAX_BEATS+1).
- A single-beat packet (`last` on the first beat) occupies LOCKED for exactly one cycle when `out_ready`=1.
- `trunc` asserts in the cycle after the releasing transfer, in IDLE, for exactly one cycle.
- Simultaneous requests resolve in rotating order from `ptr`.

## Structure
- Shared package:
  - state encoding constants `ST_IDLE`=1'b0 and `ST_LOCKED`=1'b1;
  - requester count constant `NUM_REQ`=4;
  - a function `rr_pick(req, ptr)` returning a 2-bit index.
- Sub-module: instantiate the existing `Mux4x1_Nbit` (parameter N) with `.s(sel)` for `out_data`. The arbiter logic contains no data mux of its own.

## Test plan
- **Reset, then single request:** assert `reset`, release it. Set `x0`=3 and `req`=4'b0001 with `last[0]`=1 and `out_ready`=1.
  - Required: `out_valid` in cycle 1 with `out_data`=3, `out_sel`=0 and `out_last`=1.
  - Required: IDLE next cycle and `ptr`=1.
- **All four requesting:** `x0`=3, `x1`=5, `x2`=7, `x3`=11. `req`=4'b1111 and `last`=4'b1111 held, `ptr`=0.
  - Required: grant order 0,1,2,3,0 with `out_data` sequence 3,5,7,11,3.
  - Required: one idle cycle between each grant.
- **Backpressure:** requester 2 sends a 3-beat packet with `out_ready` low for 2 cycles on beat 2.
  - Required: `out_valid` stays high, `out_data` stays stable, `beat_cnt` holds, `ready_o`=4'b0100 gated by `out_ready`.
  - Required: completes after 3 transfers.
- **Truncation:** MAX_BEATS=8, requester 1 holds `req` with `last`=0 and `out_ready`=1.
  - Required: release after 8 transfers with `out_last` on the 8th, `trunc` pulse next cycle, then the next grant goes to requesters 2/3/0 before requester 1.
- **Requester drop mid-packet:** requester 3 is granted and deasserts `req[3]` for 2 cycles while `req[0]`=1.
  - Required: `out_valid`=0 for those cycles, no grant to requester 0, packet resumes on requester 3.
- **Reset mid-packet:** pulse `reset` between edges during beat 2 of 4.
  - Required: `out_valid`/`ready_o` drop immediately, state IDLE, `ptr`=0.
  - Required: regrant starts from requester 0 with a fresh `beat_cnt`.

Source files
------------

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the four-way round-robin packet arbiter:
// FSM encoding, requester count and the rotating-priority pick function.
package rr_mux4_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;

  // First requester at or after ptr (modulo 4) with its request bit set.
  // Returns ptr when nothing is requesting; callers only use it when req != 0.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/Mux4x1_Nbit.sv
// Plain combinational 4:1 multiplexer, N bits wide, selected by s.
module Mux4x1_Nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  logic [1:0]   s,
  output logic [N-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign y[gi] = s[1] ? (s[0] ? d[gi] : c[gi])
                          : (s[0] ? b[gi] : a[gi]);
    end
  endgenerate

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin packet arbiter: locks one of four requesters onto a shared
// valid/ready channel until its last beat or the beat limit, then rotates.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [N-1:0]       x0,
  input  logic [N-1:0]       x1,
  input  logic [N-1:0]       x2,
  input  logic [N-1:0]       x3,
  output logic [NUM_REQ-1:0] ready_o,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data,
  output logic               out_last,
  output logic [1:0]         out_sel,
  output logic               busy,
  output logic               trunc
);

  localparam int             CW        = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BEATS - 1);

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          trunc_q, trunc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      sel_q      <= 2'd0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          sel_d      = rr_pick(req, ptr_q);
          beat_cnt_d = '0;
          state_d    = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        out_valid = req[sel_q];
        out_last  = req[sel_q] && (last[sel_q] || (beat_cnt_q == LAST_BEAT));
        if (out_valid && out_ready) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (out_last) begin
            // A release without the requester's own last flag is a truncation.
            trunc_d = !last[sel_q];
            ptr_d   = sel_q + 2'd1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_LOCKED);
  assign out_sel = sel_q;
  assign trunc   = trunc_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign ready_o[gi] = busy && out_ready && (sel_q == 2'(gi));
    end
  endgenerate

  Mux4x1_Nbit #(
    .N(N)
  ) u_data_mux (
    .a(x0),
    .b(x1),
    .c(x2),
    .d(x3),
    .s(sel_q),
    .y(out_data)
  );

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: a per-cycle behavioural model plus
// literal checks of grant order, data, truncation and reset behaviour.
module tb_rr_mux4_arbiter;

  localparam int N         = 4;
  localparam int MAX_BEATS = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = 4'b0;
  logic [3:0]   last = 4'b0;
  logic [N-1:0] x0 = 4'd3, x1 = 4'd5, x2 = 4'd7, x3 = 4'd11;
  logic         out_ready = 1'b1;
  logic [3:0]   ready_o;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_last;
  logic [1:0]   out_sel;
  logic         busy;
  logic         trunc;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rst_seen = 1'b0;

  typedef struct {
    int sel;
    int data;
    int lst;
    int cyc;
  } xfer_t;
  xfer_t log_q[$];

  // Behavioural model state
  int m_locked = 0, m_owner = 0, m_cnt = 0, m_ptr = 0, m_trunc = 0;

  rr_mux4_arbiter #(.N(N), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .ready_o(ready_o), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
    .busy(busy), .trunc(trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input int sel, input int data, input int lst);
    if (idx >= log_q.size()) begin
      chk({name, " missing"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      chk({name, " sel"},  32'(log_q[idx].sel),  32'(sel));
      chk({name, " data"}, 32'(log_q[idx].data), 32'(data));
      chk({name, " last"}, 32'(log_q[idx].lst),  32'(lst));
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Compare process: predicts every output from the rules, then advances the model.
  initial begin
    logic [N-1:0] xs [4];
    logic [3:0]   e_ready;
    logic         e_valid, e_last;
    int           t_next, pick;
    bit           found;
    forever begin
      @(negedge clk);
      cyc++;
      xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
      if (reset || rst_seen) begin
        m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_trunc = 0;
        rst_seen = 1'b0;
      end
      if (reset) begin
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst ready_o",   32'(ready_o),   32'd0);
        chk("rst out_last",  32'(out_last),  32'd0);
        chk("rst out_sel",   32'(out_sel),   32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst trunc",     32'(trunc),     32'd0);
        chk("rst out_data",  32'(out_data),  32'(x0));
        continue;
      end
      e_valid = (m_locked != 0) && req[m_owner];
      e_ready = 4'b0;
      if (m_locked != 0 && out_ready) e_ready[m_owner] = 1'b1;
      e_last  = e_valid && (last[m_owner] || (m_cnt == MAX_BEATS - 1));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("ready_o",   32'(ready_o),   32'(e_ready));
      chk("out_last",  32'(out_last),  32'(e_last));
      chk("out_sel",   32'(out_sel),   32'(m_owner));
      chk("out_data",  32'(out_data),  32'(xs[m_owner]));
      chk("busy",      32'(busy),      32'(m_locked));
      chk("trunc",     32'(trunc),     32'(m_trunc));
      if (out_valid && out_ready) begin
        log_q.push_back('{sel: int'(out_sel), data: int'(out_data), lst: int'(out_last), cyc: cyc});
        $display("xfer cyc=%0d sel=%0d data=%0d last=%0d", cyc, out_sel, out_data, out_last);
      end
      t_next = 0;
      if (m_locked == 0) begin
        if (req != 4'b0) begin
          found = 1'b0;
          pick  = 0;
          for (int k = 0; k < 4; k++) begin
            if (!found && req[(m_ptr + k) % 4]) begin
              pick  = (m_ptr + k) % 4;
              found = 1'b1;
            end
          end
          m_owner  = pick;
          m_cnt    = 0;
          m_locked = 1;
        end
      end else if (e_valid && out_ready) begin
        m_cnt++;
        if (e_last) begin
          if (!last[m_owner]) t_next = 1;
          m_ptr    = (m_owner + 1) % 4;
          m_locked = 0;
        end
      end
      m_trunc = t_next;
    end
  end

  initial begin
    int lst_exp;
    int order [5];
    int datas [5];
    order = '{0, 1, 2, 3, 0};
    datas = '{3, 5, 7, 11, 3};

    // Reset, then single request from requester 0
    step(2);
    reset = 1'b0;
    req = 4'b0001; last = 4'b0001; out_ready = 1'b1;
    step(1);
    #2;
    chk("t1 out_valid", 32'(out_valid), 32'd1);
    chk("t1 out_data",  32'(out_data),  32'd3);
    chk("t1 out_sel",   32'(out_sel),   32'd0);
    chk("t1 out_last",  32'(out_last),  32'd1);
    step(1);
    chk("t1 idle busy", 32'(busy), 32'd0);
    req = 4'b0011; last = 4'b0011;
    step(1);
    step(1);
    req = 4'b0000; last = 4'b0000;
    step(1);
    chk_log("t1 first", 0, 0, 3, 1);
    chk_log("t1 ptr1",  1, 1, 5, 1);

    // Clean reset so the pointer starts at 0
    reset = 1'b1;
    step(2);
    reset = 1'b0;

    // All four requesting with single-beat packets
    log_q.delete();
    req = 4'b1111; last = 4'b1111;
    step(10);
    req = 4'b0000; last = 4'b0000;
    step(1);
    chk("t2 count", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk_log($sformatf("t2 grant%0d", i), i, order[i], datas[i], 1);
    for (int i = 1; i < 5 && i < log_q.size(); i++)
      chk($sformatf("t2 gap%0d", i), 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd2);

    // Backpressure on requester 2, three beats
    log_q.delete();
    req = 4'b0100; last = 4'b0000; x2 = 4'd7;
    step(1);
    step(1);
    x2 = 4'd8; out_ready = 1'b0;
    #2;
    chk("t3 bp valid", 32'(out_valid), 32'd1);
    chk("t3 bp ready", 32'(ready_o),   32'd0);
    chk("t3 bp data",  32'(out_data),  32'd8);
    step(1);
    #2;
    chk("t3 bp2 valid", 32'(out_valid), 32'd1);
    chk("t3 bp2 data",  32'(out_data),  32'd8);
    step(1);
    out_ready = 1'b1;
    #2;
    chk("t3 ready", 32'(ready_o), 32'b0100);
    step(1);
    x2 = 4'd9; last = 4'b0100;
    #2;
    chk("t3 out_last", 32'(out_last), 32'd1);
    step(1);
    req = 4'b0000; last = 4'b0000;
    step(1);
    chk("t3 count", 32'(log_q.size()), 32'd3);
    chk_log("t3 beat1", 0, 2, 7, 0);
    chk_log("t3 beat2", 1, 2, 8, 0);
    chk_log("t3 beat3", 2, 2, 9, 1);

    // Truncation of requester 1 at the beat limit
    log_q.delete();
    req = 4'b0010; last = 4'b0000; x1 = 4'd5; x2 = 4'd7;
    step(8);
    #2;
    chk("t4 limit last", 32'(out_last), 32'd1);
    chk("t4 pre trunc",  32'(trunc),    32'd0);
    step(1);
    req = 4'b1111; last = 4'b1111;
    #2;
    chk("t4 trunc",      32'(trunc), 32'd1);
    chk("t4 trunc idle", 32'(busy),  32'd0);
    step(1);
    chk("t4 trunc end",  32'(trunc), 32'd0);
    step(7);
    req = 4'b0000; last = 4'b0000;
    step(1);
    for (int i = 0; i < 8; i++) begin
      lst_exp = (i == 7) ? 1 : 0;
      chk_log($sformatf("t4 beat%0d", i + 1), i, 1, 5, lst_exp);
    end
    chk_log("t4 next2", 8, 2, 7, 1);
    chk_log("t4 next3", 9, 3, 11, 1);
    chk_log("t4 next0", 10, 0, 3, 1);
    chk_log("t4 next1", 11, 1, 5, 1);

    // Requester 3 drops req mid-packet while requester 0 waits
    log_q.delete();
    req = 4'b1000; last = 4'b0000;
    step(2);
    req = 4'b0001;
    #2;
    chk("t5 drop valid", 32'(out_valid), 32'd0);
    chk("t5 drop busy",  32'(busy),      32'd1);
    chk("t5 drop sel",   32'(out_sel),   32'd3);
    step(1);
    #2;
    chk("t5 drop2 valid", 32'(out_valid), 32'd0);
    chk("t5 drop2 sel",   32'(out_sel),   32'd3);
    step(1);
    req = 4'b1001; last = 4'b1000;
    #2;
    chk("t5 resume valid", 32'(out_valid), 32'd1);
    chk("t5 resume last",  32'(out_last),  32'd1);
    step(1);
    req = 4'b0000; last = 4'b0000;
    step(1);
    chk("t5 count", 32'(log_q.size()), 32'd2);
    chk_log("t5 beat1", 0, 3, 11, 0);
    chk_log("t5 beat2", 1, 3, 11, 1);

    // Reset pulse mid-packet on requester 2
    log_q.delete();
    req = 4'b0001; last = 4'b0001; x0 = 4'd3;
    step(1);
    step(1);
    req = 4'b0100; last = 4'b0000; x2 = 4'd7;
    step(2);
    x2 = 4'd8; req = 4'b1111; last = 4'b0001;
    #1;
    reset = 1'b1;
    rst_seen = 1'b1;
    #1;
    chk("t6 rst valid", 32'(out_valid), 32'd0);
    chk("t6 rst ready", 32'(ready_o),   32'd0);
    chk("t6 rst busy",  32'(busy),      32'd0);
    reset = 1'b0;
    step(1);
    #2;
    chk("t6 regrant sel",  32'(out_sel),   32'd0);
    chk("t6 regrant valid",32'(out_valid), 32'd1);
    chk("t6 regrant data", 32'(out_data),  32'd3);
    step(1);
    req = 4'b0000; last = 4'b0000;
    step(1);
    chk("t6 count", 32'(log_q.size()), 32'd3);
    chk_log("t6 pre",     0, 0, 3, 1);
    chk_log("t6 beat1",   1, 2, 7, 0);
    chk_log("t6 regrant", 2, 0, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
